// File: rtl/load_store_unit.sv
// Byte/halfword/word load-store sequencer between the memory pipeline stage and a
// byte-addressed synchronous-read data memory; byte stores use read-modify-write.
module load_store_unit #(
  parameter int AddressSize = 16
) (
  input  logic                   Clock,
  input  logic                   nReset,
  input  logic                   Req,
  input  logic [2:0]             Op,
  input  logic [AddressSize-1:0] Addr,
  input  logic [31:0]            StoreData,
  output logic                   Busy,
  output logic                   Done,
  output logic                   Error,
  output logic [31:0]            LoadData,
  output logic                   MemWriteEn,
  output logic                   MemWriteL,
  output logic                   MemWriteR,
  output logic                   MemReadEn,
  output logic [AddressSize-1:0] MemAddress,
  output logic [31:0]            MemWriteData,
  input  logic [31:0]            MemReadData
);

  localparam logic [2:0] OP_LB  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LW  = 3'd2;
  localparam logic [2:0] OP_LBU = 3'd3;
  localparam logic [2:0] OP_LHU = 3'd4;
  localparam logic [2:0] OP_SB  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SW  = 3'd7;

  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, WRITE} state_t;

  state_t                 state;
  state_t                 state_next;
  logic [2:0]             req_op;
  logic [AddressSize-1:0] req_addr;
  logic [31:0]            req_data;
  logic [31:0]            merged;
  logic [31:0]            load_data;
  logic                   done;
  logic                   error;
  logic                   done_next;
  logic                   error_next;
  logic                   accept;
  logic                   misaligned;
  logic [AddressSize-1:0] word_addr;
  logic [7:0]             byte_lane;
  logic [15:0]            half_lane;
  logic [31:0]            extended;
  logic [31:0]            merged_word;

  assign word_addr = {req_addr[AddressSize-1:2], 2'b00};

  // Alignment is judged on the live request, since it decides the accepting edge.
  always_comb begin
    misaligned = 1'b0;
    case (Op)
      OP_LH, OP_LHU, OP_SH: misaligned = Addr[0];
      OP_LW, OP_SW:         misaligned = (Addr[1:0] != 2'b00);
      default:              misaligned = 1'b0;
    endcase
  end

  always_comb begin
    byte_lane = MemReadData[7:0];
    case (req_addr[1:0])
      2'd0:    byte_lane = MemReadData[7:0];
      2'd1:    byte_lane = MemReadData[15:8];
      2'd2:    byte_lane = MemReadData[23:16];
      default: byte_lane = MemReadData[31:24];
    endcase
  end

  assign half_lane = req_addr[1] ? MemReadData[31:16] : MemReadData[15:0];

  always_comb begin
    extended = MemReadData;
    case (req_op)
      OP_LB:   extended = {{24{byte_lane[7]}}, byte_lane};
      OP_LBU:  extended = {24'h0, byte_lane};
      OP_LH:   extended = {{16{half_lane[15]}}, half_lane};
      OP_LHU:  extended = {16'h0, half_lane};
      default: extended = MemReadData;
    endcase
  end

  // Byte merge for SB: only lane k takes the new byte, the rest keep the read word.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_merge
      assign merged_word[8*gi +: 8] = (req_addr[1:0] == 2'(gi)) ? req_data[7:0]
                                                                 : MemReadData[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    state_next   = state;
    done_next    = 1'b0;
    error_next   = 1'b0;
    accept       = 1'b0;
    MemReadEn    = 1'b0;
    MemWriteEn   = 1'b0;
    MemWriteL    = 1'b0;
    MemWriteR    = 1'b0;
    MemAddress   = '0;
    MemWriteData = 32'h0;
    case (state)
      IDLE: begin
        if (Req) begin
          accept = 1'b1;
          if (misaligned) begin
            done_next  = 1'b1;
            error_next = 1'b1;
          end else begin
            state_next = ACCESS;
          end
        end
      end
      ACCESS: begin
        MemAddress = word_addr;
        case (req_op)
          OP_SW: begin
            MemWriteEn   = 1'b1;
            MemWriteData = req_data;
            state_next   = IDLE;
            done_next    = 1'b1;
          end
          OP_SH: begin
            MemWriteEn   = 1'b1;
            MemWriteL    = req_addr[1];
            MemWriteR    = ~req_addr[1];
            MemWriteData = {req_data[15:0], req_data[15:0]};
            state_next   = IDLE;
            done_next    = 1'b1;
          end
          default: begin
            MemReadEn  = 1'b1;
            state_next = CAPTURE;
          end
        endcase
      end
      CAPTURE: begin
        // No strobes here: this is the read-to-write turnaround cycle.
        MemAddress = word_addr;
        if (req_op == OP_SB) begin
          state_next = WRITE;
        end else begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      WRITE: begin
        MemAddress   = word_addr;
        MemWriteEn   = 1'b1;
        MemWriteData = merged;
        state_next   = IDLE;
        done_next    = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state     <= IDLE;
      req_op    <= 3'd0;
      req_addr  <= '0;
      req_data  <= 32'h0;
      merged    <= 32'h0;
      load_data <= 32'h0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      state <= state_next;
      done  <= done_next;
      error <= error_next;
      if (accept) begin
        req_op   <= Op;
        req_addr <= Addr;
        req_data <= StoreData;
      end
      if (state == CAPTURE) begin
        if (req_op == OP_SB) begin
          merged <= merged_word;
        end else begin
          load_data <= extended;
        end
      end
    end
  end

  assign Busy     = (state != IDLE);
  assign Done     = done;
  assign Error    = error;
  assign LoadData = load_data;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a byte-addressed synchronous-read memory model.
module tb_load_store_unit;

  localparam int AW = 16;

  logic          Clock = 1'b0;
  logic          nReset = 1'b0;
  logic          Req = 1'b0;
  logic [2:0]    Op = 3'd0;
  logic [AW-1:0] Addr = '0;
  logic [31:0]   StoreData = 32'h0;
  logic          Busy, Done, Error;
  logic [31:0]   LoadData;
  logic          MemWriteEn, MemWriteL, MemWriteR, MemReadEn;
  logic [AW-1:0] MemAddress;
  logic [31:0]   MemWriteData;
  logic [31:0]   MemReadData = 32'h0;

  int tests = 0;
  int fails = 0;

  int            rd_cnt = 0;
  int            wr_cnt = 0;
  logic [AW-1:0] last_rd_addr = '0;
  logic [31:0]   last_wdata = 32'h0;
  logic          last_l = 1'b0;
  logic          last_r = 1'b0;

  logic [7:0] mem [256];

  load_store_unit #(.AddressSize(AW)) dut (
    .Clock(Clock), .nReset(nReset), .Req(Req), .Op(Op), .Addr(Addr),
    .StoreData(StoreData), .Busy(Busy), .Done(Done), .Error(Error),
    .LoadData(LoadData), .MemWriteEn(MemWriteEn), .MemWriteL(MemWriteL),
    .MemWriteR(MemWriteR), .MemReadEn(MemReadEn), .MemAddress(MemAddress),
    .MemWriteData(MemWriteData), .MemReadData(MemReadData)
  );

  always #20 Clock = ~Clock;

  // Memory: no half strobe means a full-word write; ReadData is 0 when not reading.
  always @(posedge Clock) begin
    int a;
    a = int'(MemAddress[7:0]);
    if (MemWriteEn) begin
      if (MemWriteR || !MemWriteL) begin
        mem[a]     <= MemWriteData[7:0];
        mem[a + 1] <= MemWriteData[15:8];
      end
      if (MemWriteL || !MemWriteR) begin
        mem[a + 2] <= MemWriteData[23:16];
        mem[a + 3] <= MemWriteData[31:24];
      end
    end
    MemReadData <= MemReadEn ? {mem[a + 3], mem[a + 2], mem[a + 1], mem[a]} : 32'h0;
  end

  always @(negedge Clock) begin
    if (MemReadEn === 1'b1) begin
      rd_cnt = rd_cnt + 1;
      last_rd_addr = MemAddress;
    end
    if (MemWriteEn === 1'b1) begin
      wr_cnt = wr_cnt + 1;
      last_wdata = MemWriteData;
      last_l = MemWriteL;
      last_r = MemWriteR;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one request and wait (bounded) for Done; reports latency, Error and memory activity.
  task automatic run_op(input logic [2:0] op, input logic [AW-1:0] addr, input logic [31:0] sd,
                        output int lat, output logic err, output int drd, output int dwr);
    int rd0, wr0;
    @(negedge Clock);
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    Req = 1'b1; Op = op; Addr = addr; StoreData = sd;
    @(posedge Clock); #1;
    Req = 1'b0; Op = 3'd7; Addr = '1; StoreData = 32'hFFFF_FFFF;
    lat = 1;
    while (Done !== 1'b1 && lat < 10) begin
      @(posedge Clock); #1;
      lat++;
    end
    if (Done !== 1'b1) lat = 99;
    err = Error;
    @(negedge Clock);
    drd = rd_cnt - rd0;
    dwr = wr_cnt - wr0;
    $display("[TB] op=%0d addr=0x%04h sd=0x%08h lat=%0d err=%b load=0x%08h rd=%0d wr=%0d",
             op, addr, sd, lat, err, LoadData, drd, dwr);
  endtask

  initial begin
    int lat, drd, dwr, wr0;
    logic err;

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[16] = 8'hBB; mem[17] = 8'hAA; mem[18] = 8'h99; mem[19] = 8'h88;

    repeat (2) @(posedge Clock);
    #1;
    check("rst_busy", {31'h0, Busy}, 32'h0);
    check("rst_done", {31'h0, Done}, 32'h0);
    check("rst_error", {31'h0, Error}, 32'h0);
    check("rst_loaddata", LoadData, 32'h0);
    check("rst_mem_ctl", {28'h0, MemReadEn, MemWriteEn, MemWriteL, MemWriteR}, 32'h0);
    check("rst_memaddr", {16'h0, MemAddress}, 32'h0);
    check("rst_memwdata", MemWriteData, 32'h0);
    @(negedge Clock);
    nReset = 1'b1;

    run_op(3'd0, 16'h0012, 32'h0, lat, err, drd, dwr);
    check("lb_data", LoadData, 32'hFFFF_FF99);
    check("lb_lat", lat, 32'd3);
    check("lb_err", {31'h0, err}, 32'h0);
    check("lb_memaddr", {16'h0, last_rd_addr}, 32'h0000_0010);
    @(posedge Clock); #1;
    check("done_pulse", {31'h0, Done}, 32'h0);

    run_op(3'd3, 16'h0012, 32'h0, lat, err, drd, dwr);
    check("lbu_data", LoadData, 32'h0000_0099);
    run_op(3'd1, 16'h0012, 32'h0, lat, err, drd, dwr);
    check("lh_data", LoadData, 32'hFFFF_8899);
    run_op(3'd4, 16'h0010, 32'h0, lat, err, drd, dwr);
    check("lhu_data", LoadData, 32'h0000_AABB);
    run_op(3'd2, 16'h0010, 32'h0, lat, err, drd, dwr);
    check("lw_data", LoadData, 32'h8899_AABB);
    check("lw_lat", lat, 32'd3);

    run_op(3'd5, 16'h0011, 32'h0000_005C, lat, err, drd, dwr);
    check("sb_lat", lat, 32'd4);
    check("sb_err", {31'h0, err}, 32'h0);
    check("sb_reads", drd, 32'd1);
    check("sb_writes", dwr, 32'd1);
    check("sb_wdata", last_wdata, 32'h8899_5CBB);
    check("sb_loaddata_kept", LoadData, 32'h8899_AABB);
    run_op(3'd2, 16'h0010, 32'h0, lat, err, drd, dwr);
    check("lw_after_sb", LoadData, 32'h8899_5CBB);

    run_op(3'd6, 16'h0012, 32'h0000_1234, lat, err, drd, dwr);
    check("sh_lat", lat, 32'd2);
    check("sh_reads", drd, 32'd0);
    check("sh_writes", dwr, 32'd1);
    check("sh_strobes", {30'h0, last_l, last_r}, 32'h2);
    check("sh_wdata", last_wdata, 32'h1234_1234);
    run_op(3'd2, 16'h0010, 32'h0, lat, err, drd, dwr);
    check("lw_after_sh", LoadData, 32'h1234_5CBB);

    run_op(3'd7, 16'h0014, 32'hDEAD_BEEF, lat, err, drd, dwr);
    check("sw_lat", lat, 32'd2);
    check("sw_strobes", {30'h0, last_l, last_r}, 32'h0);
    run_op(3'd2, 16'h0014, 32'h0, lat, err, drd, dwr);
    check("lw_after_sw", LoadData, 32'hDEAD_BEEF);

    run_op(3'd2, 16'h0011, 32'h0, lat, err, drd, dwr);
    check("mis_lw_lat", lat, 32'd1);
    check("mis_lw_err", {31'h0, err}, 32'h1);
    check("mis_lw_mem", drd + dwr, 32'd0);
    check("mis_lw_loaddata", LoadData, 32'hDEAD_BEEF);
    run_op(3'd6, 16'h0013, 32'h0000_5555, lat, err, drd, dwr);
    check("mis_sh_lat", lat, 32'd1);
    check("mis_sh_err", {31'h0, err}, 32'h1);
    check("mis_sh_mem", drd + dwr, 32'd0);

    run_op(3'd0, 16'h0013, 32'h0, lat, err, drd, dwr);
    check("lb_pos", LoadData, 32'h0000_0012);
    check("lb_err_clear", {31'h0, err}, 32'h0);
    run_op(3'd0, 16'h0010, 32'h0, lat, err, drd, dwr);
    check("lb_lane0", LoadData, 32'hFFFF_FFBB);
    run_op(3'd4, 16'h0012, 32'h0, lat, err, drd, dwr);
    check("lhu_upper", LoadData, 32'h0000_1234);

    @(negedge Clock);
    Req = 1'b1; Op = 3'd5; Addr = 16'h0010; StoreData = 32'h0000_0077;
    @(posedge Clock); #1;
    Req = 1'b0;
    check("rst_sb_access_rd", {31'h0, MemReadEn}, 32'h1);
    @(posedge Clock); #5;
    check("rst_sb_capture_busy", {31'h0, Busy}, 32'h1);
    wr0 = wr_cnt;
    nReset = 1'b0;
    #1;
    check("rst_sb_busy", {31'h0, Busy}, 32'h0);
    check("rst_sb_done", {31'h0, Done}, 32'h0);
    check("rst_sb_ctl", {28'h0, MemReadEn, MemWriteEn, MemWriteL, MemWriteR}, 32'h0);
    check("rst_sb_memaddr", {16'h0, MemAddress}, 32'h0);
    check("rst_sb_loaddata", LoadData, 32'h0);
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    nReset = 1'b1;
    check("rst_sb_no_write", wr_cnt - wr0, 32'd0);
    run_op(3'd2, 16'h0010, 32'h0, lat, err, drd, dwr);
    check("rst_lw_lat", lat, 32'd3);
    check("rst_lw_data", LoadData, 32'h1234_5CBB);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
